// File: rtl/dmem_responder_if.sv
// Split read/write data-memory handshake between the core (master) and
// the data RAM (slave).
//   write: wready/waddr/wdata/wstrb from core, wvalid back
//   read : rready/raddr from core, rvalid/rresp/rdata back
interface dmem_responder_if;
  logic        wready;
  logic        wvalid;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rready;
  logic        rvalid;
  logic [31:0] raddr;
  logic        rresp;
  logic [31:0] rdata;

  modport master (
    output wready, waddr, wdata, wstrb, rready, raddr,
    input  wvalid, rvalid, rresp, rdata
  );

  modport slave (
    input  wready, waddr, wdata, wstrb, rready, raddr,
    output wvalid, rvalid, rresp, rdata
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-RAM responder: 2^AW x 32 memory behind the split dmem handshake.
// Independent read and write paths, each with optional wait states,
// byte-strobed writes, registered read data and in-range response flag.
//   clk    : clock
//   resetb : asynchronous active-low reset
//   bus    : dmem_responder_if.slave (wready/wvalid/waddr/wdata/wstrb,
//            rready/rvalid/raddr/rresp/rdata)
module dmem_responder #(
  parameter int unsigned AW      = 14,
  parameter logic [3:0]  BASE    = 4'h2,
  parameter int unsigned RD_WAIT = 0,
  parameter int unsigned WR_WAIT = 0
) (
  input  logic             clk,
  input  logic             resetb,
  dmem_responder_if.slave  bus
);

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam logic [3:0]  RD_LOAD = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);
  localparam logic [3:0]  WR_LOAD = (WR_WAIT == 0) ? 4'd0 : 4'(WR_WAIT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  logic [31:0] mem_q [DEPTH];

  state_e      rd_state_q, rd_state_d;
  state_e      wr_state_q, wr_state_d;
  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic [3:0]  wr_cnt_q, wr_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rresp_q, rresp_d;
  logic        rvalid_c, wvalid_c;

  logic [AW-1:0] rd_idx, wr_idx;
  logic          rd_in, wr_in;
  logic          unused_addr_bits;

  // Address decode: word index from [AW+1:2], window selected by [31:28].
  assign rd_idx = bus.raddr[AW+1:2];
  assign wr_idx = bus.waddr[AW+1:2];
  assign rd_in  = (bus.raddr[31:28] == BASE) && ((bus.raddr[27:0] >> (AW + 2)) == 28'd0);
  assign wr_in  = (bus.waddr[31:28] == BASE) && ((bus.waddr[27:0] >> (AW + 2)) == 28'd0);
  assign unused_addr_bits = ^{bus.raddr[1:0], bus.waddr[1:0]};

  // Read wait-state FSM; zero-wait builds pass rready straight through.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rvalid_c   = 1'b0;
    if (RD_WAIT == 0) begin
      rvalid_c = bus.rready & resetb;
    end else begin
      case (rd_state_q)
        S_IDLE: if (bus.rready) begin
          rd_cnt_d   = RD_LOAD;
          rd_state_d = S_WAIT;
        end
        S_WAIT: if (!bus.rready) begin
          rd_cnt_d   = 4'd0;
          rd_state_d = S_IDLE;
        end else if (rd_cnt_q != 4'd0) begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end else begin
          rvalid_c   = 1'b1;
          rd_state_d = S_IDLE;
        end
        default: rd_state_d = S_IDLE;
      endcase
    end
  end

  // Write wait-state FSM, same structure as the read side.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wvalid_c   = 1'b0;
    if (WR_WAIT == 0) begin
      wvalid_c = bus.wready & resetb;
    end else begin
      case (wr_state_q)
        S_IDLE: if (bus.wready) begin
          wr_cnt_d   = WR_LOAD;
          wr_state_d = S_WAIT;
        end
        S_WAIT: if (!bus.wready) begin
          wr_cnt_d   = 4'd0;
          wr_state_d = S_IDLE;
        end else if (wr_cnt_q != 4'd0) begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end else begin
          wvalid_c   = 1'b1;
          wr_state_d = S_IDLE;
        end
        default: wr_state_d = S_IDLE;
      endcase
    end
  end

  // Read data capture; mem_q is sampled before this edge's write lands,
  // giving read-before-write on a same-word collision.
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (bus.rready && rvalid_c) begin
      rresp_d = rd_in;
      rdata_d = rd_in ? mem_q[rd_idx] : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd_state_q <= S_IDLE;
      wr_state_q <= S_IDLE;
      rd_cnt_q   <= 4'd0;
      wr_cnt_q   <= 4'd0;
      rdata_q    <= 32'h0;
      rresp_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Memory array is never reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (bus.wready && wvalid_c && wr_in) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) mem_q[wr_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  assign bus.rvalid = rvalid_c;
  assign bus.wvalid = wvalid_c;
  assign bus.rdata  = rdata_q;
  assign bus.rresp  = rresp_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a zero-wait instance driven from a vector
// table, and an RD_WAIT=3 / WR_WAIT=2 instance driven by hand sequences.
module tb_dmem_responder;

  logic clk;
  logic resetb;
  int   nchk;
  int   nerr;

  dmem_responder_if b0 ();
  dmem_responder_if b1 ();

  dmem_responder #(.AW(14), .BASE(4'h2), .RD_WAIT(0), .WR_WAIT(0)) dut0 (
    .clk(clk), .resetb(resetb), .bus(b0.slave));

  dmem_responder #(.AW(14), .BASE(4'h2), .RD_WAIT(3), .WR_WAIT(2)) dut1 (
    .clk(clk), .resetb(resetb), .bus(b1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        re;
    logic [31:0] raddr;
    logic        chk;
    logic [31:0] exp_rdata;
    logic        exp_rresp;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  function automatic vec_t mk(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                              input logic [3:0] ws, input logic re, input logic [31:0] ra,
                              input logic chk, input logic [31:0] er, input logic ep);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd; v.wstrb = ws;
    v.re = re; v.raddr = ra; v.chk = chk; v.exp_rdata = er; v.exp_rresp = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Holds rready on dut1 for 'cycles' cycles; rvalid expected every 4th.
  task automatic rd1_held(input logic [31:0] addr, input int cycles, input string nm);
    b1.raddr  = addr;
    b1.rready = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      #1 chk(nm, 32'(b1.rvalid), 32'((k % 4) == 3));
      @(negedge clk);
    end
    b1.rready = 1'b0;
  endtask

  // Holds wready on dut1 for 'cycles' cycles; wvalid expected every 3rd.
  task automatic wr1_held(input logic [31:0] addr, input logic [31:0] data, input int cycles,
                          input string nm);
    b1.waddr  = addr;
    b1.wdata  = data;
    b1.wstrb  = 4'hF;
    b1.wready = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      #1 chk(nm, 32'(b1.wvalid), 32'((k % 3) == 2));
      @(negedge clk);
    end
    b1.wready = 1'b0;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    resetb = 1'b0;
    b0.wready = 1'b1; b0.waddr = 32'h2000_0000; b0.wdata = 32'hFFFF_FFFF; b0.wstrb = 4'hF;
    b0.rready = 1'b1; b0.raddr = 32'h2000_0000;
    b1.wready = 1'b0; b1.waddr = 32'h0; b1.wdata = 32'h0; b1.wstrb = 4'h0;
    b1.rready = 1'b1; b1.raddr = 32'h2000_0000;

    // Reset: valids held low even with requests present.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wvalid0", 32'(b0.wvalid), 32'h0);
    chk("rst_rvalid0", 32'(b0.rvalid), 32'h0);
    chk("rst_rdata0",  b0.rdata,       32'h0);
    chk("rst_rresp0",  32'(b0.rresp),  32'h0);
    chk("rst_rvalid1", 32'(b1.rvalid), 32'h0);
    chk("rst_rdata1",  b1.rdata,       32'h0);
    @(negedge clk);
    b0.wready = 1'b0; b0.rready = 1'b0; b1.rready = 1'b0;
    resetb = 1'b1;
    @(negedge clk);

    //          we  waddr         wdata         wstrb  re  raddr         chk  exp_rdata     rresp
    vt[0]  = mk(1, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         0, 32'h0,         0);
    vt[1]  = mk(0, 32'h0,         32'h0,         4'h0, 1, 32'h2000_0010, 1, 32'hDEAD_BEEF, 1);
    vt[2]  = mk(1, 32'h2000_0010, 32'h1122_3344, 4'h5, 0, 32'h0,         0, 32'h0,         0);
    vt[3]  = mk(0, 32'h0,         32'h0,         4'h0, 1, 32'h2000_0010, 1, 32'hDE22_BE44, 1);
    vt[4]  = mk(0, 32'h0,         32'h0,         4'h0, 1, 32'h3000_0000, 1, 32'h0,         0);
    vt[5]  = mk(1, 32'h2000_0000, 32'h0102_0304, 4'hF, 0, 32'h0,         0, 32'h0,         0);
    vt[6]  = mk(1, 32'h2001_0000, 32'h5A5A_5A5A, 4'hF, 0, 32'h0,         0, 32'h0,         0);
    vt[7]  = mk(0, 32'h0,         32'h0,         4'h0, 1, 32'h2000_0000, 1, 32'h0102_0304, 1);
    vt[8]  = mk(0, 32'h0,         32'h0,         4'h0, 1, 32'h2000_0003, 1, 32'h0102_0304, 1);
    vt[9]  = mk(0, 32'h0,         32'h0,         4'h0, 0, 32'h0,         1, 32'h0102_0304, 1);
    vt[10] = mk(0, 32'h0,         32'h0,         4'h0, 1, 32'h2800_0000, 1, 32'h0,         0);
    vt[11] = mk(1, 32'h2000_0010, 32'h0,         4'hF, 0, 32'h0,         0, 32'h0,         0);
    vt[12] = mk(1, 32'h2000_0010, 32'hCAFE_F00D, 4'hF, 1, 32'h2000_0010, 1, 32'h0,         1);
    vt[13] = mk(0, 32'h0,         32'h0,         4'h0, 1, 32'h2000_0010, 1, 32'hCAFE_F00D, 1);
    vt[14] = mk(1, 32'h2000_0010, 32'hFFFF_FFFF, 4'h0, 0, 32'h0,         0, 32'h0,         0);
    vt[15] = mk(0, 32'h0,         32'h0,         4'h0, 1, 32'h2000_0010, 1, 32'hCAFE_F00D, 1);

    // Zero-wait instance: valids same cycle, read data the cycle after.
    for (int i = 0; i < NV; i++) begin
      b0.wready = vt[i].we; b0.waddr = vt[i].waddr; b0.wdata = vt[i].wdata;
      b0.wstrb  = vt[i].wstrb; b0.rready = vt[i].re; b0.raddr = vt[i].raddr;
      #1;
      chk($sformatf("v%0d_wvalid", i), 32'(b0.wvalid), 32'(vt[i].we));
      chk($sformatf("v%0d_rvalid", i), 32'(b0.rvalid), 32'(vt[i].re));
      @(negedge clk);
      if (vt[i].chk) begin
        chk($sformatf("v%0d_rdata", i), b0.rdata, vt[i].exp_rdata);
        chk($sformatf("v%0d_rresp", i), 32'(b0.rresp), 32'(vt[i].exp_rresp));
      end
    end
    b0.wready = 1'b0; b0.rready = 1'b0;

    // Wait states: write pulses every 3rd cycle, read every 4th when held.
    wr1_held(32'h2000_0040, 32'h1234_5678, 6, "ws_wvalid");
    rd1_held(32'h2000_0040, 4, "ws_rvalid_a");
    #1;
    chk("ws_rdata", b1.rdata, 32'h1234_5678);
    chk("ws_rresp", 32'(b1.rresp), 32'h1);
    @(negedge clk);
    rd1_held(32'h2000_0040, 8, "ws_rvalid_b2b");

    // Abort: two cycles of request, then drop; no pulse, data held.
    b1.raddr = 32'h3000_0000;
    b1.rready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1 chk("ab_rvalid_req", 32'(b1.rvalid), 32'h0);
      @(negedge clk);
    end
    b1.rready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("ab_rvalid_idle", 32'(b1.rvalid), 32'h0);
      @(negedge clk);
    end
    chk("ab_rdata_held", b1.rdata, 32'h1234_5678);
    chk("ab_rresp_held", 32'(b1.rresp), 32'h1);
    rd1_held(32'h3000_0000, 4, "ab_rvalid_full");
    #1;
    chk("ab_oor_rdata", b1.rdata, 32'h0);
    chk("ab_oor_rresp", 32'(b1.rresp), 32'h0);
    @(negedge clk);

    // Reset mid-WAIT with both a read and a write pending.
    rd1_held(32'h2000_0040, 4, "rw_rvalid_pre");
    b1.waddr = 32'h2000_0040; b1.wdata = 32'hFFFF_FFFF; b1.wstrb = 4'hF;
    b1.wready = 1'b1; b1.rready = 1'b1;
    @(negedge clk);
    resetb = 1'b0;
    #1;
    chk("rw_rvalid", 32'(b1.rvalid), 32'h0);
    chk("rw_wvalid", 32'(b1.wvalid), 32'h0);
    chk("rw_rdata",  b1.rdata,       32'h0);
    chk("rw_rresp",  32'(b1.rresp),  32'h0);
    @(negedge clk);
    resetb = 1'b1;
    b1.wready = 1'b0;
    rd1_held(32'h2000_0040, 4, "rw_rvalid_post");
    #1;
    chk("rw_mem_kept", b1.rdata, 32'h1234_5678);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-RAM responder: the memory end of the core's split read/write data-memory handshake.
- Sits outside the CPU top level, on the `dmem_*` ports, alongside the MMIO timer.
- Accepts one write request and one read request per cycle.
- Inserts programmable wait states, applies byte strobes, and returns registered read data plus a response flag.

Parameters:
- AW, 14, word-address width; memory depth is 2^AW 32-bit words.
- BASE, 4'h2, required value of `addr[31:28]` for an in-range access.
- RD_WAIT, 0, wait cycles inserted before a read is accepted (0..15).
- WR_WAIT, 0, wait cycles inserted before a write is accepted (0..15).

Ports:
- clk  in  1  clock
- resetb  in  1  asynchronous active-low reset
- wready  in  1  write request from core
- wvalid  out  1  write accepted this cycle
- waddr  in  32  write byte address
- wdata  in  32  write data
- wstrb  in  4  byte enables; bit i covers `wdata[8i+7:8i]`
- rready  in  1  read request from core
- rvalid  out  1  read accepted this cycle
- raddr  in  32  read byte address
- rresp  out  1  1 = last accepted read was in range; registered
- rdata  out  32  read data for last accepted read; registered

Behaviour:
- Reset: clk and resetb are the only clock and reset; reset is asynchronous, active-low.
  - While resetb=0: wvalid=0, rvalid=0, rresp=0, rdata=0.
  - Both FSMs go to IDLE and both wait counters clear.
  - Memory contents are not reset.
- Address decode:
  - Word index = `addr[AW+1:2]`; `addr[1:0]` is ignored.
  - In range iff `addr[31:28]==BASE` and `addr[27:AW+2]==0`.
- Read and write paths are independent. Each has its own FSM, IDLE/WAIT, and 4-bit counter.
- Read FSM, zero wait (RD_WAIT=0):
  - rvalid = rready, combinational, 0 extra cycles.
- Read FSM, RD_WAIT=N>0:
  - IDLE with rready=1: rvalid=0, load counter with N-1, go WAIT.
  - WAIT with counter>0: decrement.
  - WAIT with counter==0: rvalid=1, go IDLE.
  - An N-wait read is accepted N+1 cycles after rready rises.
  - Back-to-back reads each pay the full wait.
- Read data timing:
  - On the acceptance edge (rready & rvalid), rdata and rresp are registered.
  - In range: rdata <= mem[idx], rresp <= 1. Out of range: rdata <= 32'h0, rresp <= 0.
  - Both are visible in the cycle after acceptance and hold until the next accepted read.
- Write FSM: same structure as the read FSM, using WR_WAIT, wready, wvalid.
  - On the acceptance edge, each byte i with `wstrb[i]=1` is written to mem[idx].
  - wstrb=0 is accepted with no change.
  - An out-of-range write is accepted (wvalid pulses) and discarded; there is no error indication.
- Request dropped during WAIT: if rready (or wready) falls while in WAIT, return to IDLE next cycle.
  - Counter clears, no access, no valid pulse.
- Request address is sampled at acceptance only; the core must hold it stable while requesting.
- Simultaneous read and write accepted on the same edge to the same word: read returns OLD data (read-before-write). Written bytes are visible to the next accepted read.
- Reset asserted mid-WAIT: the access is abandoned, memory is unmodified, outputs return to reset values.
- Counter never wraps: it is loaded only from IDLE and decremented only while >0.

Test Plan:
1. Zero-wait write/read:
   - Write 0x20000010 ← 32'hDEADBEEF, wstrb=4'hF; wvalid=1 in the same cycle.
   - Then read 0x20000010; rvalid=1 the same cycle, and the next cycle shows rdata=32'hDEADBEEF, rresp=1.
2. Byte strobes:
   - Over 32'hDEADBEEF, write wdata=32'h11223344 with wstrb=4'b0101.
   - Read back → rdata=32'hDE22BE44.
3. Wait states, RD_WAIT=3, WR_WAIT=2:
   - wvalid pulses 3 cycles after wready rises; rvalid pulses 4 cycles after rready rises.
   - With the request held, rvalid is exactly one cycle wide, then the next read restarts the count.
4. Abort:
   - RD_WAIT=3, rready high for 2 cycles then low → no rvalid pulse; rdata and rresp are unchanged.
   - A new request takes the full 4 cycles.
5. Out of range:
   - Read 0x30000000 → rvalid=1, next cycle rresp=0, rdata=0.
   - Write 0x20000000+(1<<(AW+2)) with data 32'h5A5A5A5A → accepted, and word 0 is unchanged.
6. Same-edge collision:
   - Word 4 holds 32'h0; write 32'hCAFEF00D and read word 4 on the same edge → rdata=32'h0.
   - The following read → 32'hCAFEF00D.
   - Assert resetb=0 mid-WAIT → rvalid=0, rdata=0, FSM in IDLE.
